// File: rtl/state_sequence_driver_pkg.sv
// Shared types and constants for the state-sequence driver and its transition table.
package state_sequence_driver_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t START_STATE  = 3'b001;
    localparam state_t ACCEPT_STATE = 3'b100;

    // Sequencing of one serial bit: present candidates, strobe, let the manager settle, check.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRESENT,
        STROBE,
        SETTLE,
        CHECK
    } fsm_t;

    // One transition-table entry: destination state for X=0 and for X=1.
    typedef struct packed {
        state_t next0;
        state_t next1;
    } tbl_entry_t;

endpackage

// File: rtl/state_sequence_driver_if.sv
// Word handshake plus the state-manager exchange (sCurrent in, candidates/X/NXT out).
// slave is the driver's view, master is the producer / state-manager side.
interface state_sequence_driver_if
    import state_sequence_driver_pkg::*;
#(
    parameter int WORD_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    state_t            sCurrent;
    state_t            sNext0;
    state_t            sNext1;
    logic              X;
    logic              NXT;

    modport master (
        output in_valid, in_word, sCurrent,
        input  in_ready, sNext0, sNext1, X, NXT
    );

    modport slave (
        input  in_valid, in_word, sCurrent,
        output in_ready, sNext0, sNext1, X, NXT
    );
endinterface

// File: rtl/state_sequence_driver_table.sv
// Programmable transition table: 2^STATE_W entries, one gated write port, async read.
module seq_transition_table
    import state_sequence_driver_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       we,
    input  logic       busy,
    input  state_t     wAddr,
    input  tbl_entry_t wData,
    input  state_t     rAddr,
    output tbl_entry_t rData
);
    tbl_entry_t entries [0:(1<<STATE_W)-1];

    // Entries reset to START_STATE; writes are dropped while a word is in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < (1<<STATE_W); i++)
                entries[i] <= '{next0: START_STATE, next1: START_STATE};
        end else if (we && !busy) begin
            entries[wAddr] <= wData;
        end
    end

    assign rData = entries[rAddr];

endmodule

// File: rtl/state_sequence_driver.sv
// Transmit side of the state-manager interface: serialises a word MSB-first on X,
// presenting table-driven candidate next states and a one-cycle NXT strobe per bit.
// Optional feature macro: MATCH_COUNT_EN adds a saturating match counter (match_cnt).
module state_sequence_driver
    import state_sequence_driver_pkg::*;
#(
    parameter int WORD_W = 8
`ifdef MATCH_COUNT_EN
    ,
    parameter int CNT_W  = 8
`endif
)(
    input  logic                    CLK,
    input  logic                    nRST,
    state_sequence_driver_if.slave  sif,
    input  logic                    tbl_we,
    input  state_t                  tbl_addr,
    input  state_t                  tbl_next0,
    input  state_t                  tbl_next1,
    output logic                    busy,
    output logic                    match,
    output logic                    done
`ifdef MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]        match_cnt
`endif
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    fsm_t              state;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bitIdx;
    logic              inReadyR;
    logic              nxtR;
    logic              xR;
    logic              busyR;
    logic              matchR;
    logic              doneR;
    state_t            next0R;
    state_t            next1R;
    tbl_entry_t        wData;
    tbl_entry_t        rEntry;

    assign wData = '{next0: tbl_next0, next1: tbl_next1};

    // Lookup is always on sCurrent; only the PRESENT state consumes it.
    seq_transition_table u_table (
        .CLK   (CLK),
        .nRST  (nRST),
        .we    (tbl_we),
        .busy  (busyR),
        .wAddr (tbl_addr),
        .wData (wData),
        .rAddr (sif.sCurrent),
        .rData (rEntry)
    );

    // Bit sequencer: all outputs are registered, pulses default low every cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            shreg    <= '0;
            bitIdx   <= '0;
            inReadyR <= 1'b1;
            nxtR     <= 1'b0;
            xR       <= 1'b0;
            busyR    <= 1'b0;
            matchR   <= 1'b0;
            doneR    <= 1'b0;
            next0R   <= START_STATE;
            next1R   <= START_STATE;
        end else begin
            nxtR   <= 1'b0;
            matchR <= 1'b0;
            doneR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sif.in_valid && inReadyR) begin
                        shreg    <= sif.in_word;
                        bitIdx   <= IDX_W'(WORD_W-1);
                        inReadyR <= 1'b0;
                        busyR    <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: state <= PRESENT;
                PRESENT: begin
                    // Candidates and X land together with NXT and hold until the next PRESENT.
                    next0R <= rEntry.next0;
                    next1R <= rEntry.next1;
                    xR     <= shreg[WORD_W-1];
                    nxtR   <= 1'b1;
                    state  <= STROBE;
                end
                STROBE: state <= SETTLE;
                SETTLE: state <= CHECK;
                CHECK: begin
                    matchR <= (sif.sCurrent == ACCEPT_STATE);
                    shreg  <= shreg << 1;
                    if (bitIdx == '0) begin
                        doneR    <= 1'b1;
                        inReadyR <= 1'b1;
                        busyR    <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        bitIdx <= bitIdx - 1'b1;
                        state  <= PRESENT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MATCH_COUNT_EN
    // Counts on the same edge that raises match, so match_cnt already includes it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            match_cnt <= '0;
        else if (state == CHECK && sif.sCurrent == ACCEPT_STATE && match_cnt != '1)
            match_cnt <= match_cnt + 1'b1;
    end
`endif

    assign sif.in_ready = inReadyR;
    assign sif.NXT      = nxtR;
    assign sif.X        = xR;
    assign sif.sNext0   = next0R;
    assign sif.sNext1   = next1R;
    assign busy         = busyR;
    assign match        = matchR;
    assign done         = doneR;

endmodule
